// File: rtl/core_pkg.sv
// Shared constants and types for the pipelined RISC-V core.
package core_pkg;

    localparam int unsigned XLEN_DEFAULT   = 32;
    localparam int unsigned REG_AW_DEFAULT = 5;
    localparam int unsigned CTRL_W_DEFAULT = 8;

    // Bit positions inside the Control_Unit bundle
    localparam int unsigned CTRL_REGWRITE_BIT = 0;
    localparam int unsigned CTRL_MEMTOREG_BIT = 1;
    localparam int unsigned CTRL_MEMREAD_BIT  = 2;
    localparam int unsigned CTRL_MEMWRITE_BIT = 3;
    localparam int unsigned CTRL_BRANCH_BIT   = 4;
    localparam int unsigned CTRL_ALUSRC_BIT   = 5;
    localparam int unsigned CTRL_ALUOP_LSB    = 6;

    // Decode stage sequencing
    typedef enum logic {RUN, STALL} dec_state_e;

    // Register/function fields pulled out of a 32-bit instruction word
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       funct7_bit5;
    } instr_fields_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and write-back-to-decode bypass selects.
module hazard_detect
    import core_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
    input  logic              valid_ex,
    input  logic              memread_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              valid_dec,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              regwrite_wb,
    input  logic [REG_AW-1:0] rd_wb,
    output logic              hazard_c,
    output logic              byp1_c,
    output logic              byp2_c
);

    // A load in EX feeding a source of the decode instruction stalls; WB to the same reg bypasses
    always_comb begin
        hazard_c = valid_ex & memread_ex & (rd_ex != '0) & valid_dec &
                   ((uses_rs1 & (rs1 == rd_ex)) | (uses_rs2 & (rs2 == rd_ex)));
        byp1_c   = regwrite_wb & (rd_wb != '0) & (rd_wb == rs1);
        byp2_c   = regwrite_wb & (rd_wb != '0) & (rd_wb == rs2);
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID/EX pipeline register with handshake, flush, load-use stall and WB bypass.
module decode_stage_pipe
    import core_pkg::*;
#(
    parameter int unsigned XLEN            = XLEN_DEFAULT,
    parameter int unsigned REG_AW          = REG_AW_DEFAULT,
    parameter int unsigned CTRL_W          = CTRL_W_DEFAULT,
    parameter int unsigned MEMREAD_BIT     = CTRL_MEMREAD_BIT,
    parameter int unsigned LU_STALL_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              valid_DECODE_i,
    output logic              ready_DECODE_o,
    input  logic [31:0]       instruction_DECODE_i,
    input  logic [XLEN-1:0]   pc_DECODE_i,
    input  logic [CTRL_W-1:0] ctrl_DECODE_i,
    input  logic              uses_rs1_i,
    input  logic              uses_rs2_i,
    input  logic [XLEN-1:0]   ReadData1_i,
    input  logic [XLEN-1:0]   ReadData2_i,
    input  logic [XLEN-1:0]   Immout_i,
    input  logic [REG_AW-1:0] Write_Register_i,
    input  logic              RegWrite_i,
    input  logic [XLEN-1:0]   Write_data_i,
    input  logic              flush_i,
    input  logic              ready_EXECUTE_i,
    output logic              valid_EXECUTE_o,
    output logic [CTRL_W-1:0] ctrl_EXECUTE_o,
    output logic [XLEN-1:0]   pc_EXECUTE_o,
    output logic [REG_AW-1:0] rs1_EXECUTE_o,
    output logic [REG_AW-1:0] rs2_EXECUTE_o,
    output logic [REG_AW-1:0] rd_EXECUTE_o,
    output logic [XLEN-1:0]   ReadData1_EXECUTE_o,
    output logic [XLEN-1:0]   ReadData2_EXECUTE_o,
    output logic [XLEN-1:0]   Immout_EXECUTE_o,
    output logic [2:0]        funct3_EXECUTE_o,
    output logic              funct7_bit5_EXECUTE_o,
    output logic [31:0]       stall_count_o
);

    localparam int unsigned    CNT_W     = 3;
    localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_STALL_CYCLES - 1);

    dec_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    instr_fields_t     fields_c;
    logic [REG_AW-1:0] rs1_c, rs2_c, rd_c;
    logic              adv_c, hazard_c, byp1_c, byp2_c;
    logic              load_bubble_c, load_dec_c;
    logic [XLEN-1:0]   rd1_c, rd2_c;
    logic              unused_c;

    // Instruction field extraction and bypass muxing
    always_comb begin
        fields_c.rs1         = instruction_DECODE_i[19:15];
        fields_c.rs2         = instruction_DECODE_i[24:20];
        fields_c.rd          = instruction_DECODE_i[11:7];
        fields_c.funct3      = instruction_DECODE_i[14:12];
        fields_c.funct7_bit5 = instruction_DECODE_i[30];
        rs1_c                = REG_AW'(fields_c.rs1);
        rs2_c                = REG_AW'(fields_c.rs2);
        rd_c                 = REG_AW'(fields_c.rd);
        adv_c                = ready_EXECUTE_i | ~valid_EXECUTE_o;
        rd1_c                = byp1_c ? Write_data_i : ReadData1_i;
        rd2_c                = byp2_c ? Write_data_i : ReadData2_i;
    end

    // Opcode and remaining funct7 bits are decoded by Control_Unit, not here
    assign unused_c = ^{instruction_DECODE_i[31], instruction_DECODE_i[29:25],
                        instruction_DECODE_i[6:0]};

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .valid_ex    (valid_EXECUTE_o),
        .memread_ex  (ctrl_EXECUTE_o[MEMREAD_BIT]),
        .rd_ex       (rd_EXECUTE_o),
        .valid_dec   (valid_DECODE_i),
        .uses_rs1    (uses_rs1_i),
        .uses_rs2    (uses_rs2_i),
        .rs1         (rs1_c),
        .rs2         (rs2_c),
        .regwrite_wb (RegWrite_i),
        .rd_wb       (Write_Register_i),
        .hazard_c    (hazard_c),
        .byp1_c      (byp1_c),
        .byp2_c      (byp2_c)
    );

    // FSM state and stall countdown
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, decode handshake and EX load selection; flush has top priority
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ready_DECODE_o = 1'b0;
        load_bubble_c  = 1'b0;
        load_dec_c     = 1'b0;
        if (flush_i) begin
            ready_DECODE_o = 1'b1;
            load_bubble_c  = adv_c;
            state_d        = RUN;
            cnt_d          = '0;
        end else if (state_q == STALL) begin
            if (adv_c) begin
                load_bubble_c = 1'b1;
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
        end else if (hazard_c) begin
            if (adv_c) begin
                load_bubble_c = 1'b1;
                if (LU_STALL_CYCLES > 1) begin
                    state_d = STALL;
                    cnt_d   = LU_RELOAD;
                end
            end
        end else begin
            ready_DECODE_o = adv_c;
            load_dec_c     = adv_c;
        end
    end

    // EX register: bubble, load from decode, or hold
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_EXECUTE_o       <= 1'b0;
            ctrl_EXECUTE_o        <= '0;
            pc_EXECUTE_o          <= '0;
            rs1_EXECUTE_o         <= '0;
            rs2_EXECUTE_o         <= '0;
            rd_EXECUTE_o          <= '0;
            ReadData1_EXECUTE_o   <= '0;
            ReadData2_EXECUTE_o   <= '0;
            Immout_EXECUTE_o      <= '0;
            funct3_EXECUTE_o      <= '0;
            funct7_bit5_EXECUTE_o <= 1'b0;
        end else if (load_bubble_c) begin
            valid_EXECUTE_o       <= 1'b0;
            ctrl_EXECUTE_o        <= '0;
            pc_EXECUTE_o          <= '0;
            rs1_EXECUTE_o         <= '0;
            rs2_EXECUTE_o         <= '0;
            rd_EXECUTE_o          <= '0;
            ReadData1_EXECUTE_o   <= '0;
            ReadData2_EXECUTE_o   <= '0;
            Immout_EXECUTE_o      <= '0;
            funct3_EXECUTE_o      <= '0;
            funct7_bit5_EXECUTE_o <= 1'b0;
        end else if (load_dec_c) begin
            valid_EXECUTE_o       <= valid_DECODE_i;
            ctrl_EXECUTE_o        <= ctrl_DECODE_i;
            pc_EXECUTE_o          <= pc_DECODE_i;
            rs1_EXECUTE_o         <= rs1_c;
            rs2_EXECUTE_o         <= rs2_c;
            rd_EXECUTE_o          <= rd_c;
            ReadData1_EXECUTE_o   <= rd1_c;
            ReadData2_EXECUTE_o   <= rd2_c;
            Immout_EXECUTE_o      <= Immout_i;
            funct3_EXECUTE_o      <= fields_c.funct3;
            funct7_bit5_EXECUTE_o <= fields_c.funct7_bit5;
        end
    end

    // Saturating count of cycles a valid decode instruction was held back
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_count_o <= '0;
        end else if (valid_DECODE_i && !ready_DECODE_o && (stall_count_o != '1)) begin
            stall_count_o <= stall_count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: instance 0 uses a 1-cycle load-use stall, instance 1 a 3-cycle one.
module tb_decode_stage_pipe;
    import core_pkg::*;

    localparam logic [7:0] C_ADDI = 8'h21;
    localparam logic [7:0] C_LW   = 8'h27;
    localparam logic [7:0] C_ADD  = 8'h01;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        valid_DECODE_i;
    logic [31:0] instruction_DECODE_i, pc_DECODE_i;
    logic [7:0]  ctrl_DECODE_i;
    logic        uses_rs1_i, uses_rs2_i;
    logic [31:0] ReadData1_i, ReadData2_i, Immout_i;
    logic [4:0]  Write_Register_i;
    logic        RegWrite_i;
    logic [31:0] Write_data_i;
    logic        flush_i, ready_EXECUTE_i;

    logic        rdy_dec [2];
    logic        v_ex    [2];
    logic [7:0]  ctrl_ex [2];
    logic [31:0] pc_ex   [2];
    logic [4:0]  rs1_ex  [2];
    logic [4:0]  rs2_ex  [2];
    logic [4:0]  rd_ex   [2];
    logic [31:0] d1_ex   [2];
    logic [31:0] d2_ex   [2];
    logic [31:0] imm_ex  [2];
    logic [2:0]  f3_ex   [2];
    logic        f7_ex   [2];
    logic [31:0] stall   [2];

    int sel;
    int checks = 0;
    int errors = 0;
    int gap = 0;
    logic saw_stall = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [7:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [2:0]  f3;
        logic        f7;
        int          gap;
    } exp_t;
    exp_t q[$];

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage_pipe #(
            .LU_STALL_CYCLES ((g == 0) ? 1 : 3)
        ) dut (
            .clk_i                 (clk_i),
            .reset_ni              (reset_ni),
            .valid_DECODE_i        (valid_DECODE_i),
            .ready_DECODE_o        (rdy_dec[g]),
            .instruction_DECODE_i  (instruction_DECODE_i),
            .pc_DECODE_i           (pc_DECODE_i),
            .ctrl_DECODE_i         (ctrl_DECODE_i),
            .uses_rs1_i            (uses_rs1_i),
            .uses_rs2_i            (uses_rs2_i),
            .ReadData1_i           (ReadData1_i),
            .ReadData2_i           (ReadData2_i),
            .Immout_i              (Immout_i),
            .Write_Register_i      (Write_Register_i),
            .RegWrite_i            (RegWrite_i),
            .Write_data_i          (Write_data_i),
            .flush_i               (flush_i),
            .ready_EXECUTE_i       (ready_EXECUTE_i),
            .valid_EXECUTE_o       (v_ex[g]),
            .ctrl_EXECUTE_o        (ctrl_ex[g]),
            .pc_EXECUTE_o          (pc_ex[g]),
            .rs1_EXECUTE_o         (rs1_ex[g]),
            .rs2_EXECUTE_o         (rs2_ex[g]),
            .rd_EXECUTE_o          (rd_ex[g]),
            .ReadData1_EXECUTE_o   (d1_ex[g]),
            .ReadData2_EXECUTE_o   (d2_ex[g]),
            .Immout_EXECUTE_o      (imm_ex[g]),
            .funct3_EXECUTE_o      (f3_ex[g]),
            .funct7_bit5_EXECUTE_o (f7_ex[g]),
            .stall_count_o         (stall[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic stall_state_b();
        return g_dut[1].dut.state_q == STALL;
    endfunction

    // Monitor: pops one expected entry per EX transfer, counts bubbles in between
    always begin
        @(negedge clk_i);
        #2;
        if (!reset_ni) begin
            gap = 0;
        end else if (v_ex[sel] && ready_EXECUTE_i) begin
            if (q.size() == 0) begin
                chk("unexpected_ex_valid", 32'(pc_ex[sel]), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_pc"},   pc_ex[sel],         e.pc);
                chk({e.name, "_ctrl"}, 32'(ctrl_ex[sel]),  32'(e.ctrl));
                chk({e.name, "_rs1"},  32'(rs1_ex[sel]),   32'(e.rs1));
                chk({e.name, "_rs2"},  32'(rs2_ex[sel]),   32'(e.rs2));
                chk({e.name, "_rd"},   32'(rd_ex[sel]),    32'(e.rd));
                chk({e.name, "_rd1"},  d1_ex[sel],         e.d1);
                chk({e.name, "_rd2"},  d2_ex[sel],         e.d2);
                chk({e.name, "_imm"},  imm_ex[sel],        e.imm);
                chk({e.name, "_f3"},   32'(f3_ex[sel]),    32'(e.f3));
                chk({e.name, "_f7b5"}, 32'(f7_ex[sel]),    32'(e.f7));
                if (e.gap >= 0) chk({e.name, "_bubbles"}, 32'(gap), 32'(e.gap));
            end
            gap = 0;
        end else if (!v_ex[sel]) begin
            gap++;
        end
    end

    // Records whether the 3-cycle instance entered STALL
    always begin
        @(negedge clk_i);
        #3;
        if (stall_state_b()) saw_stall = 1'b1;
    end

    // Offer one instruction, wait for acceptance, push its expected EX image
    task automatic send(input string name, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [7:0] ctrl, input logic u1, input logic u2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [31:0] ed1, input logic [31:0] ed2,
                        input int exp_gap, input int exp_retries);
        exp_t e;
        int   retries;
        instruction_DECODE_i = ins;
        pc_DECODE_i          = pc;
        ctrl_DECODE_i        = ctrl;
        uses_rs1_i           = u1;
        uses_rs2_i           = u2;
        ReadData1_i          = d1;
        ReadData2_i          = d2;
        Immout_i             = imm;
        valid_DECODE_i       = 1'b1;
        retries              = 0;
        #1;
        while (!rdy_dec[sel] && retries < 50) begin
            @(negedge clk_i);
            #1;
            retries++;
        end
        if (!rdy_dec[sel]) begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
            valid_DECODE_i = 1'b0;
            @(negedge clk_i);
            return;
        end
        e.name = name; e.pc = pc; e.ctrl = ctrl;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.f3 = ins[14:12]; e.f7 = ins[30];
        e.d1 = ed1; e.d2 = ed2; e.imm = imm; e.gap = exp_gap;
        q.push_back(e);
        if (exp_retries >= 0) chk({name, "_stall_cycles"}, 32'(retries), 32'(exp_retries));
        @(negedge clk_i);
    endtask

    task automatic do_reset(input int s);
        valid_DECODE_i = 1'b0;
        flush_i        = 1'b0;
        @(negedge clk_i);
        sel      = s;
        reset_ni = 1'b0;
        #1;
        chk("rst_valid", 32'(v_ex[sel]), 32'd0);
        chk("rst_ctrl",  32'(ctrl_ex[sel]), 32'd0);
        chk("rst_rd",    32'(rd_ex[sel]), 32'd0);
        chk("rst_stall", stall[sel], 32'd0);
        @(negedge clk_i);
        reset_ni  = 1'b1;
        saw_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_ni = 1'b0; sel = 0; valid_DECODE_i = 1'b0; flush_i = 1'b0;
        ready_EXECUTE_i = 1'b1; RegWrite_i = 1'b0; Write_Register_i = '0; Write_data_i = '0;
        instruction_DECODE_i = '0; pc_DECODE_i = '0; ctrl_DECODE_i = '0;
        uses_rs1_i = 1'b0; uses_rs2_i = 1'b0;
        ReadData1_i = '0; ReadData2_i = '0; Immout_i = '0;

        // 1-cycle load-use stall instance
        do_reset(0);
        chk("rst_ready_idle", 32'(rdy_dec[sel]), 32'd1);
        send("addi_x1", 32'h0050_0093, 32'h0, C_ADDI, 1, 0, 0, 0, 5, 0, 0, -1, 0);
        send("lw_x5",   32'h0001_2283, 32'h4, C_LW,   1, 0, 32'h100, 0, 0, 32'h100, 0, 0, 0);
        send("add_x6",  32'h0072_8333, 32'h8, C_ADD,  1, 1, 32'h11, 32'h22, 0, 32'h11, 32'h22, 1, 1);
        valid_DECODE_i = 1'b0;
        chk("lu1_stall_count", stall[sel], 32'd1);
        repeat (3) @(negedge clk_i);

        // 3-cycle load-use stall instance
        do_reset(1);
        send("lw3_x5",  32'h0001_2283, 32'h10, C_LW,  1, 0, 32'h200, 0, 0, 32'h200, 0, -1, 0);
        send("add3_x6", 32'h0072_8333, 32'h14, C_ADD, 1, 1, 32'h33, 32'h44, 0, 32'h33, 32'h44, 3, 3);
        chk("lu3_visited_stall", 32'(saw_stall), 32'd1);
        chk("lu3_stall_count", stall[sel], 32'd3);
        send("lw_x0",   32'h0001_2003, 32'h18, C_LW,  1, 0, 32'h300, 0, 0, 32'h300, 0, 0, 0);
        send("add_x0",  32'h0070_0333, 32'h1C, C_ADD, 1, 1, 0, 32'h55, 0, 0, 32'h55, 0, 0);
        chk("lw_x0_no_stall", stall[sel], 32'd3);

        // Backpressure: EX holds its content for 4 cycles
        send("addi_hold", 32'h0050_0093, 32'h40, C_ADDI, 1, 0, 0, 0, 5, 0, 0, 0, 0);
        ready_EXECUTE_i      = 1'b0;
        instruction_DECODE_i = 32'h0070_8113;
        pc_DECODE_i          = 32'h44;
        valid_DECODE_i       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_ready_dec", 32'(rdy_dec[sel]), 32'd0);
            chk("hold_valid",     32'(v_ex[sel]), 32'd1);
            chk("hold_pc",        pc_ex[sel], 32'h40);
            chk("hold_imm",       imm_ex[sel], 32'd5);
            chk("hold_rd",        32'(rd_ex[sel]), 32'd1);
            @(negedge clk_i);
        end
        ready_EXECUTE_i = 1'b1;
        send("addi_after_hold", 32'h0070_8113, 32'h44, C_ADDI, 1, 0, 32'h5, 0, 7, 32'h5, 0, 0, 0);
        chk("hold_stall_count", stall[sel], 32'd7);

        // Flush while in STALL drops the waiting instruction
        send("lw_fl", 32'h0001_2283, 32'h80, C_LW, 1, 0, 32'h400, 0, 0, 32'h400, 0, -1, 0);
        instruction_DECODE_i = 32'h0072_8333; pc_DECODE_i = 32'h84; ctrl_DECODE_i = C_ADD;
        uses_rs1_i = 1'b1; uses_rs2_i = 1'b1;
        #1;
        for (int i = 0; i < 10 && !stall_state_b(); i++) begin
            @(negedge clk_i);
            #1;
        end
        chk("flush_reached_stall", 32'(stall_state_b()), 32'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_ready_dec", 32'(rdy_dec[sel]), 32'd1);
        @(negedge clk_i);
        flush_i        = 1'b0;
        valid_DECODE_i = 1'b0;
        #1;
        chk("flush_back_to_run", 32'(stall_state_b()), 32'd0);
        chk("flush_bubble",      32'(v_ex[sel]), 32'd0);
        chk("flush_stall_count", stall[sel], 32'd8);

        // Reset in the middle of a stall
        @(negedge clk_i);
        send("lw_rs", 32'h0001_2283, 32'hC0, C_LW, 1, 0, 32'h500, 0, 0, 32'h500, 0, -1, 0);
        instruction_DECODE_i = 32'h0072_8333; pc_DECODE_i = 32'hC4; ctrl_DECODE_i = C_ADD;
        uses_rs1_i = 1'b1; uses_rs2_i = 1'b1;
        #1;
        for (int i = 0; i < 10 && !stall_state_b(); i++) begin
            @(negedge clk_i);
            #1;
        end
        chk("rs_reached_stall", 32'(stall_state_b()), 32'd1);
        reset_ni = 1'b0;
        #1;
        chk("rs_state_run",  32'(stall_state_b()), 32'd0);
        chk("rs_bubble",     32'(v_ex[sel]), 32'd0);
        chk("rs_stall_zero", stall[sel], 32'd0);
        @(negedge clk_i);
        valid_DECODE_i = 1'b0;
        reset_ni       = 1'b1;

        // Write-back bypass
        RegWrite_i = 1'b1; Write_Register_i = 5'd3; Write_data_i = 32'hDEAD_BEEF;
        send("byp_both", 32'h0031_8233, 32'h100, C_ADD, 1, 1, 0, 0, 0,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, -1, 0);
        send("byp_rs2",  32'h0030_8233, 32'h104, C_ADD, 1, 1, 32'hAA, 0, 0,
             32'hAA, 32'hDEAD_BEEF, 0, 0);
        Write_Register_i = 5'd0; Write_data_i = 32'h1234;
        send("byp_x0",   32'h0000_0233, 32'h108, C_ADD, 1, 1, 32'h11, 32'h22, 0,
             32'h11, 32'h22, 0, 0);
        Write_Register_i = 5'd3; RegWrite_i = 1'b0;
        send("byp_off",  32'h0031_8233, 32'h10C, C_ADD, 1, 1, 32'h66, 32'h77, 0,
             32'h66, 32'h77, 0, 0);
        valid_DECODE_i = 1'b0;

        repeat (4) @(negedge clk_i);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised ID/EX pipeline register for the RISC-V pipelined core, replacing the fixed free-running decode register.
- Adds:
  - valid/ready handshake on both sides
  - branch flush with bubble insertion
  - load-use hazard detection with a configurable multi-cycle stall
  - write-back-to-decode bypass
  - a saturating stall counter
- Sits between the fetch register and the execute stage. Control_Unit, Register_File and Imm_Gen stay outside the block and feed it.

Parameters:
- XLEN, 32, datapath and PC width
- REG_AW, 5, register index width
- CTRL_W, 8, width of the packed control bundle from Control_Unit
- MEMREAD_BIT, 2, index of MemRead inside the control bundle
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (range 1..7)

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- valid_DECODE_i  in  1  decode instruction valid
- ready_DECODE_o  out  1  block accepts the decode instruction this cycle
- instruction_DECODE_i  in  32  instruction word
- pc_DECODE_i  in  XLEN  instruction PC
- ctrl_DECODE_i  in  CTRL_W  control bundle
- uses_rs1_i, uses_rs2_i  in  1 each  instruction reads rs1 / rs2
- ReadData1_i, ReadData2_i  in  XLEN each  register-file read data
- Immout_i  in  XLEN  immediate
- Write_Register_i  in  REG_AW  write-back rd
- RegWrite_i  in  1  write-back enable
- Write_data_i  in  XLEN  write-back data
- flush_i  in  1  taken branch / redirect from execute
- ready_EXECUTE_i  in  1  execute accepts
- valid_EXECUTE_o  out  1  EX register valid
- ctrl_EXECUTE_o  out  CTRL_W  registered control bundle
- pc_EXECUTE_o  out  XLEN  registered PC
- rs1_EXECUTE_o, rs2_EXECUTE_o, rd_EXECUTE_o  out  REG_AW each  registered indices
- ReadData1_EXECUTE_o, ReadData2_EXECUTE_o, Immout_EXECUTE_o  out  XLEN each  registered operands
- funct3_EXECUTE_o  out  3  registered funct3
- funct7_bit5_EXECUTE_o  out  1  registered instruction bit 30
- stall_count_o  out  32  saturating count of stall cycles

Behaviour:
- Reset (asynchronous on reset_ni low):
  - all EX outputs 0, valid_EXECUTE_o=0
  - FSM in RUN, internal countdown cnt=0
  - stall_count_o=0
- Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], funct3=instr[14:12], funct7_bit5=instr[30].
- adv = ready_EXECUTE_i | ~valid_EXECUTE_o.
- hazard = valid_EXECUTE_o & ctrl_EXECUTE_o[MEMREAD_BIT] & rd_EXECUTE_o!=0 & valid_DECODE_i & ((uses_rs1_i & rs1==rd_EXECUTE_o) | (uses_rs2_i & rs2==rd_EXECUTE_o)).
- Bypass: if RegWrite_i & Write_Register_i!=0 & Write_Register_i==rs1, the captured ReadData1 is Write_data_i. Same rule for rs2. Takes effect the same cycle.
- FSM states RUN and STALL; the rules below are listed in priority order:
  1. flush_i: if adv, EX loads a bubble. ready_DECODE_o=1, so the decode instruction is consumed and dropped. Next state RUN, cnt=0. Flush wins over hazard and STALL.
  2. STALL: ready_DECODE_o=0. On adv, EX loads a bubble and cnt decrements. When cnt==1 & adv, next state is RUN.
  3. RUN & hazard: ready_DECODE_o=0. On adv, EX loads a bubble. If LU_STALL_CYCLES>1, next state STALL with cnt=LU_STALL_CYCLES-1; otherwise stay in RUN.
  4. RUN, no hazard: ready_DECODE_o=adv. On adv, EX loads the decode fields with valid_EXECUTE_o=valid_DECODE_i.
- Bubble definition: valid_EXECUTE_o=0, ctrl_EXECUTE_o=0, rd_EXECUTE_o=0. Other EX fields are don't-care but driven to 0.
- No adv, no flush: all EX outputs hold.
- Latency: 1 cycle from decode acceptance to EX valid.
- stall_count_o increments when valid_DECODE_i & ~ready_DECODE_o, and saturates at 0xFFFF_FFFF.
- Reset asserted mid-stall returns the block to RUN with a bubble in EX.

Decomposition:
- Package core_pkg holds:
  - XLEN and REG_AW defaults
  - the control-bundle field index constants (MEMREAD_BIT, REGWRITE_BIT, …)
  - typedef enum logic {RUN, STALL} dec_state_e
- One sub-module, hazard_detect: combinational; computes hazard and the two bypass selects.

Test Plan:
- Reset then stream addi x1,x0,5 (pc 0x0) with ready_EXECUTE_i=1 -> next cycle valid_EXECUTE_o=1, rd_EXECUTE_o=1, Immout_EXECUTE_o=5, pc_EXECUTE_o=0.
- lw x5,0(x2) followed by add x6,x5,x7, LU_STALL_CYCLES=1 -> one bubble (valid_EXECUTE_o=0), ready_DECODE_o low exactly 1 cycle, stall_count_o=1, then add enters EX.
- Same sequence with LU_STALL_CYCLES=3 -> 3 bubbles, FSM visits STALL, stall_count_o=3; lw x0 as the producer -> no stall.
- ready_EXECUTE_i=0 for 4 cycles with valid EX content -> all EX outputs stable, ready_DECODE_o=0; release -> next instruction loads.
- flush_i=1 during STALL -> bubble loaded, ready_DECODE_o=1, FSM returns to RUN next cycle.
- Write_Register_i=3, RegWrite_i=1, Write_data_i=0xDEADBEEF while decoding add x4,x3,x3 with stale ReadData=0 -> both ReadData1_EXECUTE_o and ReadData2_EXECUTE_o equal 0xDEADBEEF.
